// File: rtl/adder_pkg.sv
// Shared definitions for the 8-bit prefix adder: the propagate/generate pair
// and the prefix combine operator used by every tree level.
package adder_pkg;

  localparam int ADDER_W = 8;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  // (g,p) o (g',p') = (g | p&g', p&p'); hi is the more significant group
  function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/pg_prefix_level.sv
// One Kogge-Stone level: bit i combines with bit i-SPAN; bits below SPAN
// already hold their final group value and pass straight through.
module pg_prefix_level
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_W,
  parameter int SPAN  = 1
) (
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= SPAN) begin : g_comb
      pg_t r;
      assign r = pg_combine(pg_t'{g: g_in[i], p: p_in[i]},
                            pg_t'{g: g_in[i-SPAN], p: p_in[i-SPAN]});
      assign g_out[i] = r.g;
      assign p_out[i] = r.p;
    end else begin : g_pass
      assign g_out[i] = g_in[i];
      assign p_out[i] = p_in[i];
    end
  end

endmodule

// File: rtl/pg_carry_pipe.sv
// Pipelined front end of the prefix adder: S1 forms P/G and folds the
// carry-in into bit 0, S2 runs spans 1 and 2, S3 runs the remaining spans
// and registers the carries. Valid/ready elastic pipeline, bubbles collapse.
module pg_carry_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_W,
  parameter int LOG2W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] G,
  output logic [WIDTH-1:0] Ci,
  output logic             C0_o
);

  logic             vld_p1, vld_p2, vld_p3;
  logic             adv_p1, adv_p2, adv_p3;
  logic [WIDTH-1:0] p_p1, g_p1, gg_p1;
  logic             c0_p1;
  logic [WIDTH-1:0] p_p2, g_p2, gg_p2, gp_p2;
  logic             c0_p2;
  logic [WIDTH-1:0] p_p3, g_p3, ci_p3;
  logic             c0_p3;
  logic [WIDTH-1:0] gg_d;
  logic [WIDTH-1:0] g_l1, p_l1, g_l2, p_l2;
  logic [WIDTH-1:0] ci_d;

  // Each stage moves when it is empty or the next stage moves; in_ready
  // therefore depends only on registered valids and out_ready.
  assign adv_p3   = !vld_p3 || out_ready;
  assign adv_p2   = !vld_p2 || adv_p3;
  assign adv_p1   = !vld_p1 || adv_p2;
  assign in_ready = adv_p1;

  // Group generate entering the tree: bit 0 absorbs the carry-in
  always_comb begin
    gg_d    = A & B;
    gg_d[0] = (A[0] & B[0]) | ((A[0] | B[0]) & C0);
  end

  // ---- S1 -> S2: spans 1 and 2
  pg_prefix_level #(.WIDTH(WIDTH), .SPAN(1)) u_lvl1 (
    .g_in(gg_p1), .p_in(p_p1), .g_out(g_l1), .p_out(p_l1)
  );
  pg_prefix_level #(.WIDTH(WIDTH), .SPAN(2)) u_lvl2 (
    .g_in(g_l1), .p_in(p_l1), .g_out(g_l2), .p_out(p_l2)
  );

  // ---- S2 -> S3: spans 4 .. WIDTH/2
  for (genvar l = 2; l < LOG2W; l++) begin : g_s3
    logic [WIDTH-1:0] g_i, p_i, g_o, p_o;
    if (l == 2) begin : g_first
      assign g_i = gg_p2;
      assign p_i = gp_p2;
    end else begin : g_next
      assign g_i = g_s3[l-1].g_o;
      assign p_i = g_s3[l-1].p_o;
    end
    pg_prefix_level #(.WIDTH(WIDTH), .SPAN(1 << l)) u_lvl (
      .g_in(g_i), .p_in(p_i), .g_out(g_o), .p_out(p_o)
    );
  end

  if (LOG2W > 2) begin : g_ci_tree
    // The final group propagate has no consumer; only the carries matter.
    logic [WIDTH-1:0] grp_p_unused;
    assign ci_d         = g_s3[LOG2W-1].g_o;
    assign grp_p_unused = g_s3[LOG2W-1].p_o;
  end else begin : g_ci_direct
    assign ci_d = gg_p2;
  end

  // Stage registers: valids follow the advance chain, data loads only when
  // a valid item moves in; everything clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      p_p1   <= '0; g_p1 <= '0; gg_p1 <= '0; c0_p1 <= 1'b0;
      p_p2   <= '0; g_p2 <= '0; gg_p2 <= '0; gp_p2 <= '0; c0_p2 <= 1'b0;
      p_p3   <= '0; g_p3 <= '0; ci_p3 <= '0; c0_p3 <= 1'b0;
    end else begin
      // ---- S1
      if (adv_p1) begin
        vld_p1 <= in_valid;
        if (in_valid) begin
          p_p1  <= A | B;
          g_p1  <= A & B;
          gg_p1 <= gg_d;
          c0_p1 <= C0;
        end
      end
      // ---- S2
      if (adv_p2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          p_p2  <= p_p1;
          g_p2  <= g_p1;
          gg_p2 <= g_l2;
          gp_p2 <= p_l2;
          c0_p2 <= c0_p1;
        end
      end
      // ---- S3
      if (adv_p3) begin
        vld_p3 <= vld_p2;
        if (vld_p2) begin
          p_p3  <= p_p2;
          g_p3  <= g_p2;
          ci_p3 <= ci_d;
          c0_p3 <= c0_p2;
        end
      end
    end
  end

  assign out_valid = vld_p3;
  assign P         = p_p3;
  assign G         = g_p3;
  assign Ci        = ci_p3;
  assign C0_o      = c0_p3;

endmodule

// File: tb/tb_pg_carry_pipe.sv
// Bench for pg_carry_pipe: accepted transactions go into a scoreboard queue,
// an independent monitor pops and checks each emitted result against an
// arithmetic model (ripple sums per bit) and the downstream sum equation.
module tb_pg_carry_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, C0;
  logic         out_valid, out_ready, C0_o;
  logic [W-1:0] A, B, P, G, Ci;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
  } txn_t;

  txn_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_pop  = 0;

  always #5 clk = ~clk;

  pg_carry_pipe #(.WIDTH(W), .LOG2W(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .C0(C0), .out_valid(out_valid), .out_ready(out_ready),
    .P(P), .G(G), .Ci(Ci), .C0_o(C0_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Carry out of bit i is bit i+1 of the sum of the low i+1 bits plus C0.
  function automatic logic [W-1:0] ref_carries(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic c);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      int unsigned m, s;
      m = (32'd1 << (i + 1)) - 1;
      s = (32'(a) & m) + (32'(b) & m) + 32'(c);
      r[i] = s[i+1];
    end
    return r;
  endfunction

  // Monitor: checks each transfer, flags unexpected output, and checks that
  // a stalled output holds steady.
  logic        hold_prev = 1'b0;
  logic [31:0] prev_out  = '0;
  always @(negedge clk) begin
    txn_t        t;
    logic [W-1:0] s;
    logic [8:0]  e;
    #1;
    if (hold_prev) chk("hold", {6'd0, out_valid, C0_o, Ci, G, P}, prev_out);
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got out_valid=1, expected no pending item (t=%0t)", $time);
      end else if (out_ready) begin
        t = sb.pop_front();
        n_pop++;
        chk("P", 32'(P), 32'(t.a | t.b));
        chk("G", 32'(G), 32'(t.a & t.b));
        chk("Ci", 32'(Ci), 32'(ref_carries(t.a, t.b, t.c)));
        chk("C0_o", 32'(C0_o), 32'(t.c));
        s = G ^ P ^ {Ci[W-2:0], C0_o};
        e = 9'(t.a) + 9'(t.b) + 9'(t.c);
        chk("sum", 32'({Ci[W-1], s}), 32'(e));
      end
    end
    hold_prev = (out_valid === 1'b1) && !out_ready && !rst;
    prev_out  = {6'd0, out_valid, C0_o, Ci, G, P};
  end

  task automatic cyc(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic c, input logic ordy, output logic acc);
    txn_t t;
    @(negedge clk);
    in_valid  = v;
    A         = a;
    B         = b;
    C0        = c;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (acc) begin
      t.a = a; t.b = b; t.c = c;
      sb.push_back(t);
    end
  endtask

  task automatic drain(input string name);
    logic acc;
    int   k = 0;
    while (sb.size() != 0 && k < 50) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b1, acc);
      k++;
    end
    cyc(1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk({name, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic        acc;
    int          k, n0, acc_cnt, cycles;
    logic [W-1:0] va[5], vb[5];
    logic        vc[5];

    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; C0 = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_data", {6'd0, C0_o, Ci, G, P}, 32'd0);

    // Single transaction: latency from accept to out_valid
    cyc(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1, acc);
    chk("lat_accept", 32'(acc), 32'd1);
    k = 0;
    do begin
      cyc(1'b0, '0, '0, 1'b0, 1'b1, acc);
      k++;
    end while (out_valid !== 1'b1 && k < 10);
    chk("latency", 32'(k), 32'd3);
    drain("lat");

    // Directed vectors back to back
    va = '{8'h0F, 8'h00, 8'hFF, 8'h80, 8'h55};
    vb = '{8'h01, 8'h00, 8'hFF, 8'h80, 8'hAA};
    vc = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, va[i], vb[i], vc[i], 1'b1, acc);
      chk("dir_accept", 32'(acc), 32'd1);
    end
    drain("dir");

    // Back-pressure: only three fit, then in_ready drops and outputs hold
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, acc);
      chk("bp_accept", 32'(acc), (i < 3) ? 32'd1 : 32'd0);
    end
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    n0 = n_pop;
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1, acc);
    #1;
    chk("bp_drain_count", 32'(n_pop - n0), 32'd3);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Full throughput: one accept per cycle with out_ready high
    k = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, acc);
      if (acc) k++;
    end
    chk("throughput", 32'(k), 32'd20);
    drain("thr");

    // Reset with two transactions in flight
    cyc(1'b1, 8'h12, 8'h34, 1'b1, 1'b1, acc);
    cyc(1'b1, 8'hC3, 8'h5A, 1'b0, 1'b1, acc);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b1, acc);
      chk("post_rst_quiet", 32'(out_valid), 32'd0);
    end

    // Random traffic with random back-pressure
    acc_cnt = 0;
    cycles  = 0;
    while (acc_cnt < 10000 && cycles < 60000) begin
      cyc($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom),
          $urandom_range(0, 3) != 0, acc);
      if (acc) acc_cnt++;
      cycles++;
    end
    chk("random_accepted", 32'(acc_cnt), 32'd10000);
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
